// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command packet controller.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        CMD_S,
        ADDR_S,
        LEN_S,
        DATA,
        CHK_S,
        COMMIT,
        SKIP,
        RESP
    } state_e;

    // Saturating 8-bit increment used for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: synchronous write, combinational read by commit index.
module uart_cmd_buf #(
    parameter int unsigned BUF_AW = 4
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [BUF_AW-1:0] i_wr_idx,
    input  logic [7:0]        i_wr_data,
    input  logic [BUF_AW-1:0] i_rd_idx,
    output logic [7:0]        o_rd_data
);

    localparam int unsigned DEPTH = 1 << BUF_AW;

    logic [7:0] r_mem [DEPTH];

    // Store payload bytes as they arrive; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames received bytes into write packets, verifies the XOR checksum, commits
// the buffered payload as register writes and answers with ACK/NAK.
module uart_cmd_ctrl #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned BUF_AW  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_ready,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_eop,
    output logic       o_reg_wr_en,
    output logic [7:0] o_reg_wr_addr,
    output logic [7:0] o_reg_wr_data,
    input  logic       i_reg_wr_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    import uart_cmd_pkg::*;

    localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

    state_e     r_state,     w_state_nxt;
    logic [7:0] r_addr,      w_addr_nxt;
    logic [7:0] r_len,       w_len_nxt;
    logic [7:0] r_idx,       w_idx_nxt;
    logic [7:0] r_chk,       w_chk_nxt;
    logic [7:0] r_err_cnt,   w_err_nxt;
    logic       r_wr_en,     w_wr_en_nxt;
    logic [7:0] r_wr_addr,   w_wr_addr_nxt;
    logic [7:0] r_wr_data,   w_wr_data_nxt;
    logic       r_tx_valid,  w_tx_valid_nxt;
    logic [7:0] r_tx_data,   w_tx_data_nxt;
    logic       r_busy,      w_busy_nxt;

    logic              w_err_inc;
    logic              w_buf_we;
    logic [BUF_AW-1:0] w_rd_idx;
    logic [7:0]        w_rd_data;
    logic              w_wr_hs;
    logic              w_abort;

    // Read index: buf[0] while waiting for CHK (prefetch), next entry during commit.
    assign w_rd_idx = (r_state == COMMIT) ? (BUF_AW'(r_idx) + BUF_AW'(1)) : '0;
    assign w_wr_hs  = r_wr_en & i_reg_wr_ready;
    // End-of-packet without a byte in the same cycle truncates a packet in progress.
    assign w_abort  = i_rx_eop & ~i_rx_ready;

    uart_cmd_buf #(
        .BUF_AW (BUF_AW)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_buf_we),
        .i_wr_idx  (BUF_AW'(r_idx)),
        .i_wr_data (i_rx_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // State register and registered outputs; reset cancels everything in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_addr     <= 8'd0;
            r_len      <= 8'd0;
            r_idx      <= 8'd0;
            r_chk      <= 8'd0;
            r_err_cnt  <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_idx      <= w_idx_nxt;
            r_chk      <= w_chk_nxt;
            r_err_cnt  <= w_err_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state, datapath and output decode for the packet FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_len_nxt      = r_len;
        w_idx_nxt      = r_idx;
        w_chk_nxt      = r_chk;
        w_err_nxt      = r_err_cnt;
        w_wr_en_nxt    = r_wr_en;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_data_nxt  = r_tx_data;
        w_err_inc      = 1'b0;
        w_buf_we       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_rx_ready && (i_rx_data == SYNC_BYTE)) begin
                    w_state_nxt = CMD_S;
                end
            end
            CMD_S: begin
                if (i_rx_ready) begin
                    if (i_rx_data == CMD_WR) begin
                        w_chk_nxt   = i_rx_data;
                        w_state_nxt = ADDR_S;
                    end else begin
                        w_state_nxt = SKIP;
                    end
                end else if (w_abort) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            ADDR_S: begin
                if (i_rx_ready) begin
                    w_addr_nxt  = i_rx_data;
                    w_chk_nxt   = r_chk ^ i_rx_data;
                    w_state_nxt = LEN_S;
                end else if (w_abort) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            LEN_S: begin
                if (i_rx_ready) begin
                    if ((i_rx_data == 8'd0) || (i_rx_data > LP_MAX_LEN)) begin
                        w_state_nxt = SKIP;
                    end else begin
                        w_len_nxt   = i_rx_data;
                        w_idx_nxt   = 8'd0;
                        w_chk_nxt   = r_chk ^ i_rx_data;
                        w_state_nxt = DATA;
                    end
                end else if (w_abort) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (i_rx_ready) begin
                    w_buf_we  = 1'b1;
                    w_chk_nxt = r_chk ^ i_rx_data;
                    if (r_idx == r_len - 8'd1) begin
                        w_state_nxt = CHK_S;
                    end else begin
                        w_idx_nxt = r_idx + 8'd1;
                    end
                end else if (w_abort) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            CHK_S: begin
                if (i_rx_ready) begin
                    if (i_rx_data == r_chk) begin
                        // First write goes out straight from the prefetched buf[0].
                        w_idx_nxt     = 8'd0;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = w_rd_data;
                        w_state_nxt   = COMMIT;
                    end else begin
                        w_err_inc      = 1'b1;
                        w_tx_valid_nxt = 1'b1;
                        w_tx_data_nxt  = NAK_BYTE;
                        w_state_nxt    = RESP;
                    end
                end else if (w_abort) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            COMMIT: begin
                if (i_rx_ready) begin
                    w_err_inc = 1'b1;
                end
                if (w_wr_hs) begin
                    if (r_idx == r_len - 8'd1) begin
                        w_wr_en_nxt    = 1'b0;
                        w_tx_valid_nxt = 1'b1;
                        w_tx_data_nxt  = ACK_BYTE;
                        w_state_nxt    = RESP;
                    end else begin
                        w_idx_nxt     = r_idx + 8'd1;
                        w_wr_addr_nxt = r_wr_addr + 8'd1;
                        w_wr_data_nxt = w_rd_data;
                    end
                end
            end
            SKIP: begin
                if (w_abort) begin
                    w_err_inc      = 1'b1;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = NAK_BYTE;
                    w_state_nxt    = RESP;
                end
            end
            RESP: begin
                if (i_rx_ready) begin
                    w_err_inc = 1'b1;
                end
                if (i_tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_err_inc) begin
            w_err_nxt = sat_inc8(r_err_cnt);
        end
    end

    assign w_busy_nxt = (w_state_nxt != IDLE);

    assign o_reg_wr_en   = r_wr_en;
    assign o_reg_wr_addr = r_wr_addr;
    assign o_reg_wr_data = r_wr_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_tx_data     = r_tx_data;
    assign o_busy        = r_busy;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_eop;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic [7:0] err_cnt;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    uart_cmd_ctrl #(
        .MAX_LEN (16),
        .BUF_AW  (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_ready     (rx_ready),
        .i_rx_data      (rx_data),
        .i_rx_eop       (rx_eop),
        .o_reg_wr_en    (reg_wr_en),
        .o_reg_wr_addr  (reg_wr_addr),
        .o_reg_wr_data  (reg_wr_data),
        .i_reg_wr_ready (reg_wr_ready),
        .o_tx_valid     (tx_valid),
        .o_tx_data      (tx_data),
        .i_tx_ready     (tx_ready),
        .o_busy         (busy),
        .o_err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Log handshakes mid-cycle; inputs are stable until the next rising edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reg_wr_en && reg_wr_ready) wr_q.push_back('{cyc, reg_wr_addr, reg_wr_data});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic pulse_eop();
        rx_eop = 1'b1;
        step();
        rx_eop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 60 && busy; k++) step();
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rx_eop = 1'b0;
        reg_wr_ready = 1'b1; tx_ready = 1'b1;
        step(); step();
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data, tx_valid, tx_data, busy, err_cnt} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b a=%h d=%h txv=%b txd=%h busy=%b err=%h required all 0",
                     reg_wr_en, reg_wr_addr, reg_wr_data, tx_valid, tx_data, busy, err_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_valid_write();
        logic [7:0] ea[3] = '{8'h10, 8'h11, 8'h12};
        logic [7:0] ed[3] = '{8'hAA, 8'hBB, 8'hCC};
        wr_q.delete(); tx_q.delete();
        put(8'hA5); put(8'h01); put(8'h10); put(8'h03);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hCF);
        n_run++;
        if (reg_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL valid_first_en: got %b required 1", reg_wr_en);
        end
        wait_idle("valid");
        n_run++;
        if (wr_q.size() != 3) begin
            n_fail++; $display("FAIL valid_wr_count: got %0d required 3", wr_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            if (k < wr_q.size()) begin
                n_run++;
                if (wr_q[k].a !== ea[k] || wr_q[k].d !== ed[k]) begin
                    n_fail++;
                    $display("FAIL valid_wr%0d: got (%h,%h) required (%h,%h)",
                             k, wr_q[k].a, wr_q[k].d, ea[k], ed[k]);
                end
            end
        end
        if (wr_q.size() == 3) begin
            n_run++;
            if (wr_q[2].c - wr_q[0].c != 2) begin
                n_fail++;
                $display("FAIL valid_back_to_back: cycle span %0d required 2", wr_q[2].c - wr_q[0].c);
            end
        end
        n_run++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            n_fail++; $display("FAIL valid_ack: got %0d bytes first %h required 1 byte 06",
                               tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'hxx);
        end
        n_run++;
        if (err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL valid_err: got %h required 00", err_cnt);
        end
    endtask

    task automatic test_bad_chk();
        wr_q.delete(); tx_q.delete();
        put(8'hA5); put(8'h01); put(8'h10); put(8'h03);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hCE);
        n_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
            n_fail++; $display("FAIL badchk_nak: txv=%b txd=%h required 1/15", tx_valid, tx_data);
        end
        wait_idle("badchk");
        n_run++;
        if (wr_q.size() != 0 || tx_q.size() != 1 || err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL badchk_result: writes=%0d tx=%0d err=%h required 0/1/01",
                               wr_q.size(), tx_q.size(), err_cnt);
        end
    endtask

    task automatic test_wrap_backpressure();
        wr_q.delete(); tx_q.delete();
        reg_wr_ready = 1'b0;
        put(8'hA5); put(8'h01); put(8'hFF); put(8'h02);
        put(8'h11); put(8'h22); put(8'hCF);
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 8'hFF, 8'h11}) begin
            n_fail++; $display("FAIL wrap_first: en=%b a=%h d=%h required 1/FF/11",
                               reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        step();
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 8'hFF, 8'h11}) begin
            n_fail++; $display("FAIL wrap_stall0: en=%b a=%h d=%h required 1/FF/11",
                               reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        reg_wr_ready = 1'b1; step(); reg_wr_ready = 1'b0;
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 8'h00, 8'h22}) begin
            n_fail++; $display("FAIL wrap_second: en=%b a=%h d=%h required 1/00/22",
                               reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        step();
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data} !== {1'b1, 8'h00, 8'h22}) begin
            n_fail++; $display("FAIL wrap_stall1: en=%b a=%h d=%h required 1/00/22",
                               reg_wr_en, reg_wr_addr, reg_wr_data);
        end
        reg_wr_ready = 1'b1; step();
        n_run++;
        if (reg_wr_en !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h06) begin
            n_fail++; $display("FAIL wrap_resp: en=%b txv=%b txd=%h required 0/1/06",
                               reg_wr_en, tx_valid, tx_data);
        end
        step();
        n_run++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_busy_fall: busy=%b txv=%b required 0/0", busy, tx_valid);
        end
        n_run++;
        if (wr_q.size() != 2 || tx_q.size() != 1) begin
            n_fail++; $display("FAIL wrap_counts: writes=%0d tx=%0d required 2/1", wr_q.size(), tx_q.size());
        end else begin
            n_run++;
            if (wr_q[0].a !== 8'hFF || wr_q[0].d !== 8'h11 || wr_q[1].a !== 8'h00
                || wr_q[1].d !== 8'h22 || tx_q[0] !== 8'h06) begin
                n_fail++; $display("FAIL wrap_log: (%h,%h) (%h,%h) tx %h required (FF,11) (00,22) 06",
                                   wr_q[0].a, wr_q[0].d, wr_q[1].a, wr_q[1].d, tx_q[0]);
            end
        end
    endtask

    task automatic test_truncated();
        wr_q.delete(); tx_q.delete();
        put(8'hA5); put(8'h01); put(8'h20); put(8'h04); put(8'h01); put(8'h02);
        pulse_eop();
        n_run++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL trunc_abort: busy=%b txv=%b err=%h required 0/0/02",
                               busy, tx_valid, err_cnt);
        end
        step(); step();
        n_run++;
        if (wr_q.size() != 0 || tx_q.size() != 0) begin
            n_fail++; $display("FAIL trunc_quiet: writes=%0d tx=%0d required 0/0", wr_q.size(), tx_q.size());
        end
        // Single-byte payload follows right after the aborted packet.
        put(8'hA5); put(8'h01); put(8'h30); put(8'h01); put(8'h5A); put(8'h6A);
        wait_idle("trunc_next");
        n_run++;
        if (wr_q.size() != 1 || tx_q.size() != 1) begin
            n_fail++; $display("FAIL trunc_next_counts: writes=%0d tx=%0d required 1/1",
                               wr_q.size(), tx_q.size());
        end else begin
            n_run++;
            if (wr_q[0].a !== 8'h30 || wr_q[0].d !== 8'h5A || tx_q[0] !== 8'h06) begin
                n_fail++; $display("FAIL trunc_next_data: (%h,%h) tx %h required (30,5A) 06",
                                   wr_q[0].a, wr_q[0].d, tx_q[0]);
            end
        end
    endtask

    task automatic test_illegal();
        wr_q.delete(); tx_q.delete();
        put(8'hA5); put(8'h01); put(8'h00); put(8'h00); put(8'h33);
        pulse_eop();
        n_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h15) begin
            n_fail++; $display("FAIL illegal_len_nak: txv=%b txd=%h required 1/15", tx_valid, tx_data);
        end
        wait_idle("illegal_len");
        put(8'hA5); put(8'h07); put(8'h44);
        pulse_eop();
        wait_idle("illegal_cmd");
        n_run++;
        if (wr_q.size() != 0 || tx_q.size() != 2 || err_cnt !== 8'd4) begin
            n_fail++; $display("FAIL illegal_result: writes=%0d tx=%0d err=%h required 0/2/04",
                               wr_q.size(), tx_q.size(), err_cnt);
        end else begin
            n_run++;
            if (tx_q[0] !== 8'h15 || tx_q[1] !== 8'h15) begin
                n_fail++; $display("FAIL illegal_bytes: %h %h required 15 15", tx_q[0], tx_q[1]);
            end
        end
    endtask

    task automatic test_reset_commit();
        wr_q.delete(); tx_q.delete();
        reg_wr_ready = 1'b0;
        put(8'hA5); put(8'h01); put(8'h50); put(8'h02); put(8'h01); put(8'h02); put(8'h50);
        n_run++;
        if (reg_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL rstc_commit_en: got %b required 1", reg_wr_en);
        end
        step();
        rst = 1'b1;
        step();
        n_run++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data, tx_valid, tx_data, busy, err_cnt} !== 35'd0) begin
            n_fail++; $display("FAIL rstc_outputs: en=%b a=%h d=%h txv=%b txd=%h busy=%b err=%h required 0",
                               reg_wr_en, reg_wr_addr, reg_wr_data, tx_valid, tx_data, busy, err_cnt);
        end
        rst = 1'b0;
        reg_wr_ready = 1'b1;
        for (int k = 0; k < 8; k++) step();
        n_run++;
        if (wr_q.size() != 0 || tx_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstc_cancel: writes=%0d tx=%0d busy=%b required 0/0/0",
                               wr_q.size(), tx_q.size(), busy);
        end
    endtask

    task automatic test_overrun();
        wr_q.delete(); tx_q.delete();
        tx_ready = 1'b0;
        put(8'hA5); put(8'h01); put(8'h40); put(8'h01); put(8'h77); put(8'h37);
        for (int k = 0; k < 20 && !tx_valid; k++) step();
        n_run++;
        if (tx_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovr_resp_timeout: txv=%b required 1", tx_valid);
        end
        put(8'h99);
        n_run++;
        if (err_cnt !== 8'd1 || tx_valid !== 1'b1 || tx_data !== 8'h06) begin
            n_fail++; $display("FAIL ovr_drop: err=%h txv=%b txd=%h required 01/1/06",
                               err_cnt, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        step();
        n_run++;
        if (busy !== 1'b0 || tx_q.size() != 1 || wr_q.size() != 1) begin
            n_fail++; $display("FAIL ovr_done: busy=%b tx=%0d writes=%0d required 0/1/1",
                               busy, tx_q.size(), wr_q.size());
        end else begin
            n_run++;
            if (tx_q[0] !== 8'h06 || wr_q[0].a !== 8'h40 || wr_q[0].d !== 8'h77) begin
                n_fail++; $display("FAIL ovr_data: tx %h write (%h,%h) required 06 (40,77)",
                                   tx_q[0], wr_q[0].a, wr_q[0].d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_write();
        test_bad_chk();
        test_wrap_backpressure();
        test_truncated();
        test_illegal();
        test_reset_commit();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
